// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M multiplier: op encodings, FSM states
// and the stall length the EX stage and benches rely on.
package mul_pkg;

  localparam int XLEN            = 32;
  localparam int CHUNK_BITS      = 8;
  localparam int NCHUNK          = XLEN / CHUNK_BITS;
  localparam int MUL_BUSY_CYCLES = NCHUNK + 1;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_FINAL = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_operand_prep.sv
// Converts RV32M operands into unsigned magnitudes plus the sign of the product,
// so the datapath only ever multiplies unsigned values.
module mul_operand_prep
  import mul_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_mag_a,
  output logic [WIDTH-1:0] o_mag_b,
  output logic             o_neg
);

  logic w_a_signed;
  logic w_b_signed;
  logic w_a_neg;
  logic w_b_neg;

  // MUL only yields the low word, which is sign-independent, so it stays unsigned.
  assign w_a_signed = (i_op == MUL_OP_MULH) || (i_op == MUL_OP_MULHSU);
  assign w_b_signed = (i_op == MUL_OP_MULH);

  assign w_a_neg = w_a_signed & i_op_a[WIDTH-1];
  assign w_b_neg = w_b_signed & i_op_b[WIDTH-1];

  assign o_mag_a = w_a_neg ? (~i_op_a + 1'b1) : i_op_a;
  assign o_mag_b = w_b_neg ? (~i_op_b + 1'b1) : i_op_b;
  assign o_neg   = w_a_neg ^ w_b_neg;

endmodule

// File: rtl/mul_iter_unit.sv
// Multi-cycle RV32M multiplier: consumes CHUNK_BITS of the multiplier per cycle
// into a double-width accumulator and applies the sign in a final cycle.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int XLEN_P       = XLEN,
  parameter int CHUNK_BITS_P = CHUNK_BITS
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mul_start,
  input  logic [1:0]        i_mul_op,
  input  logic [XLEN_P-1:0] i_op_a,
  input  logic [XLEN_P-1:0] i_op_b,
  input  logic [4:0]        i_rd_in,
  input  logic              i_flush,
  output logic              o_mul_busy,
  output logic              o_mul_done,
  output logic [XLEN_P-1:0] o_mul_result,
  output logic [4:0]        o_rd_out
);

  localparam int NCHUNK_P = XLEN_P / CHUNK_BITS_P;
  localparam int CNT_W    = (NCHUNK_P > 1) ? $clog2(NCHUNK_P) : 1;

  mul_state_e          r_state;
  logic [XLEN_P-1:0]   r_mag_b;
  logic [2*XLEN_P-1:0] r_shift_a;
  logic [2*XLEN_P-1:0] r_acc;
  logic                r_neg;
  logic [1:0]          r_op;
  logic [4:0]          r_rd;
  logic [CNT_W-1:0]    r_cnt;

  logic [XLEN_P-1:0]   w_mag_a;
  logic [XLEN_P-1:0]   w_mag_b;
  logic                w_neg;
  logic [2*XLEN_P-1:0] w_pp;
  logic [2*XLEN_P-1:0] w_prod;

  mul_operand_prep #(.WIDTH(XLEN_P)) u_prep (
    .i_op    (i_mul_op),
    .i_op_a  (i_op_a),
    .i_op_b  (i_op_b),
    .o_mag_a (w_mag_a),
    .o_mag_b (w_mag_b),
    .o_neg   (w_neg)
  );

  // r_shift_a already carries the k*CHUNK_BITS weight; r_mag_b shifts down so its low chunk is current.
  assign w_pp   = r_shift_a * {{(2*XLEN_P-CHUNK_BITS_P){1'b0}}, r_mag_b[CHUNK_BITS_P-1:0]};
  assign w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_mag_b      <= '0;
      r_shift_a    <= '0;
      r_acc        <= '0;
      r_neg        <= 1'b0;
      r_op         <= MUL_OP_MUL;
      r_rd         <= '0;
      r_cnt        <= '0;
      o_mul_busy   <= 1'b0;
      o_mul_done   <= 1'b0;
      o_mul_result <= '0;
      o_rd_out     <= '0;
    end else if (i_flush) begin
      r_state    <= ST_IDLE;
      o_mul_busy <= 1'b0;
      o_mul_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_mul_done <= 1'b0;
          if (i_mul_start) begin
            r_shift_a  <= {{XLEN_P{1'b0}}, w_mag_a};
            r_mag_b    <= w_mag_b;
            r_neg      <= w_neg;
            r_op       <= i_mul_op;
            r_rd       <= i_rd_in;
            r_acc      <= '0;
            r_cnt      <= '0;
            o_mul_busy <= 1'b1;
            r_state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_acc     <= r_acc + w_pp;
          r_shift_a <= r_shift_a << CHUNK_BITS_P;
          r_mag_b   <= r_mag_b >> CHUNK_BITS_P;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(NCHUNK_P - 1)) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          o_mul_result <= (r_op == MUL_OP_MUL) ? w_prod[XLEN_P-1:0] : w_prod[2*XLEN_P-1:XLEN_P];
          o_rd_out     <= r_rd;
          o_mul_done   <= 1'b1;
          o_mul_busy   <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          o_mul_busy <= 1'b0;
          o_mul_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed self-checking bench for mul_iter_unit: arithmetic per op, busy/done
// timing, back-to-back issue, ignored starts, flush and mid-op reset.
module tb_mul_iter_unit;
  import mul_pkg::*;

  logic        clk;
  logic        reset;
  logic        mul_start;
  logic [1:0]  mul_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_result;
  logic [4:0]  rd_out;

  int assertCount;
  int failCount;

  mul_iter_unit dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_mul_start  (mul_start),
    .i_mul_op     (mul_op),
    .i_op_a       (op_a),
    .i_op_b       (op_b),
    .i_rd_in      (rd_in),
    .i_flush      (flush),
    .o_mul_busy   (mul_busy),
    .o_mul_done   (mul_done),
    .o_mul_result (mul_result),
    .o_rd_out     (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a one-cycle start pulse; returns at the negedge right after the sampling edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    mul_start = 1'b1;
    mul_op    = op;
    op_a      = a;
    op_b      = b;
    rd_in     = rd;
    @(negedge clk);
    mul_start = 1'b0;
  endtask

  // Waits at negedges for done, counting busy cycles; bounded so a stuck DUT still ends.
  task automatic waitDone(output int busyCycles, output logic seen);
    busyCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mul_done) begin
        seen = 1'b1;
        break;
      end
      if (mul_busy) busyCycles++;
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expected);
    int   busyCycles;
    logic seen;
    applyStimulus(op, a, b, rd);
    waitDone(busyCycles, seen);
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_result"}, mul_result, expected);
    checkOutput({tag, "_rd"}, 32'(rd_out), 32'(rd));
  endtask

  initial begin
    int   busyCycles;
    int   gap;
    int   doneCount;
    logic seen;

    assertCount = 0;
    failCount   = 0;
    reset     = 1'b1;
    mul_start = 1'b0;
    mul_op    = MUL_OP_MUL;
    op_a      = '0;
    op_b      = '0;
    rd_in     = '0;
    flush     = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(mul_busy), 32'd0);
    checkOutput("reset_done", 32'(mul_done), 32'd0);
    checkOutput("reset_result", mul_result, 32'd0);
    checkOutput("reset_rd", 32'(rd_out), 32'd0);
    reset = 1'b0;

    // Basic MUL with timing: busy for exactly MUL_BUSY_CYCLES, done one cycle wide.
    applyStimulus(MUL_OP_MUL, 32'd3, 32'd4, 5'd3);
    waitDone(busyCycles, seen);
    checkOutput("mul3x4_done_seen", 32'(seen), 32'd1);
    checkOutput("mul3x4_busy_cycles", 32'(busyCycles), 32'd5);
    checkOutput("mul3x4_result", mul_result, 32'h0000000C);
    checkOutput("mul3x4_rd", 32'(rd_out), 32'd3);
    checkOutput("mul3x4_busy_in_done", 32'(mul_busy), 32'd0);
    @(negedge clk);
    checkOutput("mul3x4_done_width", 32'(mul_done), 32'd0);
    checkOutput("mul3x4_result_held", mul_result, 32'h0000000C);

    runOp("mulh_m1xm1", MUL_OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000000);
    runOp("mulh_minxm1", MUL_OP_MULH, 32'h80000000, 32'hFFFFFFFF, 5'd5, 32'h00000000);
    runOp("mul_minxm1", MUL_OP_MUL, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h80000000);
    runOp("mulhsu_max", MUL_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF);
    runOp("mulhu_max", MUL_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE);
    runOp("mulhu_2p31x4", MUL_OP_MULHU, 32'h80000000, 32'd4, 5'd12, 32'h00000002);
    runOp("mul_m2x3", MUL_OP_MUL, 32'hFFFFFFFE, 32'd3, 5'd13, 32'hFFFFFFFA);
    runOp("mulh_m2x3", MUL_OP_MULH, 32'hFFFFFFFE, 32'd3, 5'd14, 32'hFFFFFFFF);
    runOp("mulhsu_2xmax", MUL_OP_MULHSU, 32'd2, 32'hFFFFFFFF, 5'd15, 32'h00000001);
    runOp("mul_mixed", MUL_OP_MUL, 32'h00012345, 32'h00000100, 5'd31, 32'h01234500);

    // Back-to-back: second start issued in the done cycle of the first.
    applyStimulus(MUL_OP_MUL, 32'd5, 32'd6, 5'd1);
    waitDone(busyCycles, seen);
    checkOutput("b2b_first_seen", 32'(seen), 32'd1);
    checkOutput("b2b_first_result", mul_result, 32'd30);
    mul_start = 1'b1;
    mul_op    = MUL_OP_MUL;
    op_a      = 32'd5;
    op_b      = 32'd5;
    rd_in     = 5'd7;
    @(negedge clk);
    mul_start = 1'b0;
    checkOutput("b2b_second_accepted", 32'(mul_busy), 32'd1);
    gap = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mul_done) begin
        seen = 1'b1;
        break;
      end
      gap++;
      @(negedge clk);
    end
    checkOutput("b2b_second_seen", 32'(seen), 32'd1);
    checkOutput("b2b_done_spacing", 32'(gap), 32'(MUL_BUSY_CYCLES + 1));
    checkOutput("b2b_second_result", mul_result, 32'd25);
    checkOutput("b2b_second_rd", 32'(rd_out), 32'd7);

    // A start pulse while busy must not launch a second operation.
    applyStimulus(MUL_OP_MUL, 32'd9, 32'd9, 5'd9);
    @(negedge clk);
    mul_start = 1'b1;
    op_a      = 32'd2;
    op_b      = 32'd2;
    rd_in     = 5'd2;
    @(negedge clk);
    mul_start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 16; i++) begin
      if (mul_done) doneCount++;
      @(negedge clk);
    end
    checkOutput("busy_start_done_count", 32'(doneCount), 32'd1);
    checkOutput("busy_start_result", mul_result, 32'd81);
    checkOutput("busy_start_rd", 32'(rd_out), 32'd9);

    // Flush in the third busy cycle: busy drops, no done, old result kept.
    applyStimulus(MUL_OP_MUL, 32'd100, 32'd100, 5'd20);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy_drop", 32'(mul_busy), 32'd0);
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      if (mul_done) doneCount++;
      @(negedge clk);
    end
    checkOutput("flush_no_done", 32'(doneCount), 32'd0);
    checkOutput("flush_result_kept", mul_result, 32'd81);
    checkOutput("flush_rd_kept", 32'(rd_out), 32'd9);
    runOp("after_flush", MUL_OP_MUL, 32'd11, 32'd13, 5'd11, 32'd143);

    // Flush together with a start in IDLE drops the start.
    @(negedge clk);
    mul_start = 1'b1;
    flush     = 1'b1;
    op_a      = 32'd3;
    op_b      = 32'd3;
    @(negedge clk);
    mul_start = 1'b0;
    flush     = 1'b0;
    checkOutput("flush_start_dropped", 32'(mul_busy), 32'd0);

    // Reset mid-ACCUM aborts immediately.
    applyStimulus(MUL_OP_MUL, 32'h0000FFFF, 32'h0000FFFF, 5'd17);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", 32'(mul_busy), 32'd0);
    checkOutput("midreset_done", 32'(mul_done), 32'd0);
    checkOutput("midreset_result", mul_result, 32'd0);
    checkOutput("midreset_rd", 32'(rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (mul_done) doneCount++;
      @(negedge clk);
    end
    checkOutput("midreset_no_done", 32'(doneCount), 32'd0);
    runOp("after_reset", MUL_OP_MUL, 32'd7, 32'd6, 5'd21, 32'h0000002A);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
